// File: rtl/irom_port_arbiter.sv
// ============================================================================
// Module   : irom_port_arbiter
// Purpose  : Round-robin share of one combinational instruction ROM between
//            core fetch (IF) and the data/debug load port (DP), registered
//            1-cycle responses with alignment/range error reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irom_port_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                ROM_WORDS = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0,
  parameter logic [DATA_W-1:0] NOP_WORD  = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  // IF requester
  input  logic              i_if_req_valid,
  output logic              o_if_req_ready,
  input  logic [ADDR_W-1:0] i_if_req_addr,
  input  logic              i_if_flush,
  output logic              o_if_rsp_valid,
  input  logic              i_if_rsp_ready,
  output logic [DATA_W-1:0] o_if_rsp_data,
  output logic              o_if_rsp_err,
  // DP requester
  input  logic              i_dp_req_valid,
  output logic              o_dp_req_ready,
  input  logic [ADDR_W-1:0] i_dp_req_addr,
  output logic              o_dp_rsp_valid,
  input  logic              i_dp_rsp_ready,
  output logic [DATA_W-1:0] o_dp_rsp_data,
  output logic              o_dp_rsp_err,
  // ROM
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data
);

  localparam logic [ADDR_W:0] c_ROM_BYTES = (ADDR_W+1)'(4 * ROM_WORDS);

  typedef enum logic [0:0] {
    GNT_IF = 1'b0,
    GNT_DP = 1'b1
  } grant_t;

  grant_t            r_last_grant;
  grant_t            w_last_grant_nxt;
  logic              w_elig_if;
  logic              w_elig_dp;
  logic              w_gnt_if;
  logic              w_gnt_dp;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [ADDR_W:0]   w_diff;
  logic              w_err;
  logic [DATA_W-1:0] w_rsp_data;

  logic              r_if_rsp_valid;
  logic [DATA_W-1:0] r_if_rsp_data;
  logic              r_if_rsp_err;
  logic              r_dp_rsp_valid;
  logic [DATA_W-1:0] r_dp_rsp_data;
  logic              r_dp_rsp_err;

  // A port may only win when its response slot is empty or draining this cycle.
  assign w_elig_if = i_if_req_valid && !i_if_flush && (!r_if_rsp_valid || i_if_rsp_ready);
  assign w_elig_dp = i_dp_req_valid && (!r_dp_rsp_valid || i_dp_rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GNT_DP;
    end else begin
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_gnt_if         = 1'b0;
    w_gnt_dp         = 1'b0;
    w_last_grant_nxt = r_last_grant;
    if (!rst) begin
      if (w_elig_if && (!w_elig_dp || r_last_grant == GNT_DP)) begin
        w_gnt_if         = 1'b1;
        w_last_grant_nxt = GNT_IF;
      end else if (w_elig_dp) begin
        w_gnt_dp         = 1'b1;
        w_last_grant_nxt = GNT_DP;
      end
    end
  end

  assign o_if_req_ready = w_gnt_if;
  assign o_dp_req_ready = w_gnt_dp;

  // The extra top bit of w_diff is the borrow, flagging addresses below BASE_ADDR.
  assign w_sel_addr = w_gnt_dp ? i_dp_req_addr : i_if_req_addr;
  assign w_diff     = {1'b0, w_sel_addr} - {1'b0, BASE_ADDR};
  assign o_rom_addr = w_diff[ADDR_W-1:0];
  assign w_err      = (w_sel_addr[1:0] != 2'b00) || (w_diff >= c_ROM_BYTES);
  assign w_rsp_data = w_err ? NOP_WORD : i_rom_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_if_rsp_err   <= 1'b0;
    end else if (w_gnt_if) begin
      r_if_rsp_valid <= 1'b1;
      r_if_rsp_data  <= w_rsp_data;
      r_if_rsp_err   <= w_err;
    end else if (i_if_flush || i_if_rsp_ready) begin
      r_if_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_rsp_valid <= 1'b0;
      r_dp_rsp_data  <= '0;
      r_dp_rsp_err   <= 1'b0;
    end else if (w_gnt_dp) begin
      r_dp_rsp_valid <= 1'b1;
      r_dp_rsp_data  <= w_rsp_data;
      r_dp_rsp_err   <= w_err;
    end else if (i_dp_rsp_ready) begin
      r_dp_rsp_valid <= 1'b0;
    end
  end

  assign o_if_rsp_valid = r_if_rsp_valid;
  assign o_if_rsp_data  = r_if_rsp_data;
  assign o_if_rsp_err   = r_if_rsp_err;
  assign o_dp_rsp_valid = r_dp_rsp_valid;
  assign o_dp_rsp_data  = r_dp_rsp_data;
  assign o_dp_rsp_err   = r_dp_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_irom_port_arbiter.sv
// ============================================================================
// Module   : tb_irom_port_arbiter
// Purpose  : Directed scenarios plus a response scoreboard for irom_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req_valid, i_if_flush, i_if_rsp_ready;
  logic [31:0] i_if_req_addr;
  logic        i_dp_req_valid, i_dp_rsp_ready;
  logic [31:0] i_dp_req_addr;
  logic        o_if_req_ready, o_if_rsp_valid, o_if_rsp_err;
  logic        o_dp_req_ready, o_dp_rsp_valid, o_dp_rsp_err;
  logic [31:0] o_if_rsp_data, o_dp_rsp_data;
  logic [31:0] o_rom_addr;
  logic [31:0] w_rom_data;

  int checks   = 0;
  int failures = 0;

  logic [32:0] q_if[$];
  logic [32:0] q_dp[$];

  always #5 clk = ~clk;

  irom_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_if_req_valid (i_if_req_valid),
    .o_if_req_ready (o_if_req_ready),
    .i_if_req_addr  (i_if_req_addr),
    .i_if_flush     (i_if_flush),
    .o_if_rsp_valid (o_if_rsp_valid),
    .i_if_rsp_ready (i_if_rsp_ready),
    .o_if_rsp_data  (o_if_rsp_data),
    .o_if_rsp_err   (o_if_rsp_err),
    .i_dp_req_valid (i_dp_req_valid),
    .o_dp_req_ready (o_dp_req_ready),
    .i_dp_req_addr  (i_dp_req_addr),
    .o_dp_rsp_valid (o_dp_rsp_valid),
    .i_dp_rsp_ready (i_dp_rsp_ready),
    .o_dp_rsp_data  (o_dp_rsp_data),
    .o_dp_rsp_err   (o_dp_rsp_err),
    .o_rom_addr     (o_rom_addr),
    .i_rom_data     (w_rom_data)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] off);
    case (off)
      32'h00:  rom_word = 32'h10013537;
      32'h04:  rom_word = 32'h00452583;
      32'h08:  rom_word = 32'h0045f593;
      32'h14:  rom_word = 32'h00010637;
      default: rom_word = 32'h00000013;
    endcase
  endfunction

  // ROM word lookup ignores the low address bits, like a real word-wide ROM.
  assign w_rom_data = rom_word({o_rom_addr[31:2], 2'b00});

  // Expected {err, data} for a request address (BASE_ADDR=0, 64 words).
  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    logic e;
    e = (a[1:0] != 2'b00) || (a >= 32'h100);
    exp_rsp = e ? {1'b1, 32'h00000013} : {1'b0, rom_word(a)};
  endfunction

  // Scoreboard: push on accept, pop on consume or flush.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (o_if_rsp_valid !== (q_if.size() != 0)) begin
        failures++;
        $display("FAIL sb_if_valid: got %b want %b", o_if_rsp_valid, q_if.size() != 0);
      end else if (q_if.size() != 0) begin
        checks++;
        if ({o_if_rsp_err, o_if_rsp_data} !== q_if[0]) begin
          failures++;
          $display("FAIL sb_if_rsp: got %h want %h", {o_if_rsp_err, o_if_rsp_data}, q_if[0]);
        end
      end
      checks++;
      if (o_dp_rsp_valid !== (q_dp.size() != 0)) begin
        failures++;
        $display("FAIL sb_dp_valid: got %b want %b", o_dp_rsp_valid, q_dp.size() != 0);
      end else if (q_dp.size() != 0) begin
        checks++;
        if ({o_dp_rsp_err, o_dp_rsp_data} !== q_dp[0]) begin
          failures++;
          $display("FAIL sb_dp_rsp: got %h want %h", {o_dp_rsp_err, o_dp_rsp_data}, q_dp[0]);
        end
      end
      if ((i_if_rsp_ready || i_if_flush) && q_if.size() != 0) void'(q_if.pop_front());
      if (i_dp_rsp_ready && q_dp.size() != 0) void'(q_dp.pop_front());
      if (o_if_req_ready === 1'b1) q_if.push_back(exp_rsp(i_if_req_addr));
      if (o_dp_req_ready === 1'b1) q_dp.push_back(exp_rsp(i_dp_req_addr));
    end else begin
      q_if.delete();
      q_dp.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_if_req_valid = 1'b0;
    i_dp_req_valid = 1'b0;
    i_if_flush     = 1'b0;
    i_if_rsp_ready = 1'b1;
    i_dp_rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    i_if_req_valid = 1'b1;
    i_dp_req_valid = 1'b1;
    i_if_req_addr  = 32'h0;
    i_dp_req_addr  = 32'h14;
    @(negedge clk);
    checks++;
    if ({o_if_req_ready, o_dp_req_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b want 00", {o_if_req_ready, o_dp_req_ready});
    end
    tick();
    tick();
    i_if_req_valid = 1'b0;
    i_dp_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_if_rsp_valid, o_if_rsp_err, o_if_rsp_data, o_dp_rsp_valid, o_dp_rsp_err, o_dp_rsp_data} !== '0) begin
      failures++;
      $display("FAIL reset_rsp: got if %b/%b/%h dp %b/%b/%h want all 0",
               o_if_rsp_valid, o_if_rsp_err, o_if_rsp_data, o_dp_rsp_valid, o_dp_rsp_err, o_dp_rsp_data);
    end
    tick();
  endtask

  task automatic test_first_tie();
    i_if_req_valid = 1'b1;
    i_dp_req_valid = 1'b1;
    i_if_req_addr  = 32'h0;
    i_dp_req_addr  = 32'h14;
    @(negedge clk);
    checks++;
    if ({o_if_req_ready, o_dp_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL t1_grant0: got %b want 10", {o_if_req_ready, o_dp_req_ready});
    end
    tick();
    i_if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_dp_req_ready, o_if_rsp_valid, o_if_rsp_data} !== {2'b11, 32'h10013537}) begin
      failures++;
      $display("FAIL t1_if_rsp: got dprdy=%b v=%b d=%h want 1 1 10013537",
               o_dp_req_ready, o_if_rsp_valid, o_if_rsp_data);
    end
    tick();
    i_dp_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_dp_rsp_valid, o_dp_rsp_data} !== {1'b1, 32'h00010637}) begin
      failures++;
      $display("FAIL t1_dp_rsp: got v=%b d=%h want 1 00010637", o_dp_rsp_valid, o_dp_rsp_data);
    end
    tick();
  endtask

  task automatic test_alternate();
    i_if_req_valid = 1'b1;
    i_dp_req_valid = 1'b1;
    i_if_req_addr  = 32'h0;
    i_dp_req_addr  = 32'h14;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({o_if_req_ready, o_dp_req_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL t2_alt[%0d]: got %b want %b", c, {o_if_req_ready, o_dp_req_ready},
                 (c % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      if (c % 2 == 0) i_if_req_addr = i_if_req_addr + 32'h4;
    end
    idle();
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] addrs[3];
    logic [32:0] want[3];
    addrs = '{32'h6, 32'h100, 32'hFC};
    want  = '{{1'b1, 32'h13}, {1'b1, 32'h13}, {1'b0, 32'h13}};
    i_dp_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_dp_req_addr = addrs[i];
      tick();
      if (i == 2) i_dp_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_dp_rsp_valid, o_dp_rsp_err, o_dp_rsp_data} !== {1'b1, want[i]}) begin
        failures++;
        $display("FAIL t3_err[%0d]: got v=%b e=%b d=%h want 1 %h", i,
                 o_dp_rsp_valid, o_dp_rsp_err, o_dp_rsp_data, want[i]);
      end
    end
    tick();
  endtask

  task automatic test_stall();
    i_if_req_valid = 1'b1;
    i_if_req_addr  = 32'h8;
    i_if_rsp_ready = 1'b0;
    i_dp_req_valid = 1'b1;
    i_dp_req_addr  = 32'h4;
    @(negedge clk);
    checks++;
    if ({o_if_req_ready, o_dp_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL t4_first: got %b want 10", {o_if_req_ready, o_dp_req_ready});
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({o_if_req_ready, o_dp_req_ready, o_if_rsp_data} !== {2'b01, 32'h0045f593}) begin
        failures++;
        $display("FAIL t4_stall[%0d]: got rdy=%b%b d=%h want 01 0045f593", c,
                 o_if_req_ready, o_dp_req_ready, o_if_rsp_data);
      end
      tick();
    end
    i_if_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_if_req_ready, o_dp_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL t4_resume: got %b want 10", {o_if_req_ready, o_dp_req_ready});
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_flush();
    i_if_req_valid = 1'b1;
    i_if_req_addr  = 32'h0;
    i_if_rsp_ready = 1'b0;
    tick();
    i_if_flush    = 1'b1;
    i_if_req_addr = 32'h4;
    @(negedge clk);
    checks++;
    if ({o_if_rsp_valid, o_if_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL t5_flush: got v=%b rdy=%b want 1 0", o_if_rsp_valid, o_if_req_ready);
    end
    tick();
    i_if_flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_if_rsp_valid, o_if_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL t5_after: got v=%b rdy=%b want 0 1", o_if_rsp_valid, o_if_req_ready);
    end
    tick();
    i_if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_if_rsp_valid, o_if_rsp_data} !== {1'b1, 32'h00452583}) begin
      failures++;
      $display("FAIL t5_rsp: got v=%b d=%h want 1 00452583", o_if_rsp_valid, o_if_rsp_data);
    end
    i_if_rsp_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    i_if_req_valid = 1'b1;
    i_dp_req_valid = 1'b1;
    i_if_req_addr  = 32'h8;
    i_dp_req_addr  = 32'h14;
    i_if_rsp_ready = 1'b0;
    i_dp_rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_if_req_ready, o_dp_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL t6_pre: got %b want 01", {o_if_req_ready, o_dp_req_ready});
    end
    tick();
    tick();
    rst = 1'b1;
    i_if_req_valid = 1'b0;
    i_dp_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_if_rsp_valid, o_dp_rsp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL t6_cleared: got %b want 00", {o_if_rsp_valid, o_dp_rsp_valid});
    end
    tick();
    i_if_req_valid = 1'b1;
    i_dp_req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_if_req_ready, o_dp_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL t6_tie: got %b want 10", {o_if_req_ready, o_dp_req_ready});
    end
    tick();
    idle();
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_if_req_addr = '0;
    i_dp_req_addr = '0;
    idle();
    test_reset();
    test_first_tie();
    test_alternate();
    test_errors();
    test_stall();
    test_flush();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
